// File: rtl/clk_div_checker_pkg.sv
// Shared clock-gen definitions for the divided-clock checker: state encoding,
// parameter defaults and the good-period rule.
package clk_div_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } chk_state_t;

    localparam int RATIO_WD_DEF   = 4;
    localparam int CNT_WD_DEF     = 6;
    localparam int LOCK_COUNT_DEF = 3;
    localparam int TIMEOUT_DEF    = 40;

    // Odd ratios have two legal duty splits, so either rounding of R/2 is accepted.
    function automatic logic period_is_good(input int unsigned period,
                                            input int unsigned high,
                                            input int unsigned ratio);
        return (period == ratio) && ((high == ratio / 2) || (high == (ratio + 1) / 2));
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Single-register edge detector for a clock that is synchronous to clk;
// rise/fall are combinational against the registered copy.
module clk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic d_q;

    // NOTE: sequential state is always assigned with <= so every register in the
    // block samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= sig;
        end
    end

    assign rise = sig & ~d_q;
    assign fall = ~sig & d_q;

endmodule

// File: rtl/clk_div_checker.sv
// Receive-side checker for a divided clock: measures period and high phase in
// reference cycles and reports lock, per-period mismatch and loss-of-clock.
module clk_div_checker
    import clk_div_checker_pkg::*;
#(
    parameter int RATIO_WD   = RATIO_WD_DEF,
    parameter int CNT_WD     = CNT_WD_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_chk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    input  logic                i_div_clk,
    output logic [CNT_WD-1:0]   o_period,
    output logic [CNT_WD-1:0]   o_high,
    output logic                o_valid,
    output logic                o_err,
    output logic                o_lock,
    output logic                o_lost
);

    localparam int MATCH_WD = $clog2(LOCK_COUNT + 1);
    localparam int IDLE_WD  = $clog2(TIMEOUT + 1);

    localparam logic [MATCH_WD-1:0] MATCH_MAX = MATCH_WD'(LOCK_COUNT);
    localparam logic [MATCH_WD-1:0] MATCH_PRE = MATCH_WD'(LOCK_COUNT - 1);
    localparam logic [IDLE_WD-1:0]  IDLE_LAST = IDLE_WD'(TIMEOUT - 1);
    localparam logic [CNT_WD-1:0]   CNT_ONE   = CNT_WD'(1);

    chk_state_t          state;
    logic [RATIO_WD-1:0] ratio_q;
    logic [CNT_WD-1:0]   cnt_q;
    logic [CNT_WD-1:0]   hi_q;
    logic [MATCH_WD-1:0] match_q;
    logic [IDLE_WD-1:0]  idle_q;

    logic rise;
    logic fall;
    logic timeout_hit;
    logic period_good;

    clk_edge_det u_edge_det (
        .clk  (i_ref_clk),
        .rst  (i_rst),
        .sig  (i_div_clk),
        .rise (rise),
        .fall (fall)
    );

    // A rise in the same cycle as the timeout wins, so the timeout is masked by it.
    assign timeout_hit = !rise && (idle_q == IDLE_LAST);
    assign period_good = period_is_good(32'(cnt_q), 32'(hi_q), 32'(ratio_q));

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            ratio_q  <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            match_q  <= '0;
            idle_q   <= '0;
            o_period <= '0;
            o_high   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_lock   <= 1'b0;
            o_lost   <= 1'b0;
        end else if (!i_chk_en) begin
            state    <= IDLE;
            ratio_q  <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            match_q  <= '0;
            idle_q   <= '0;
            o_period <= '0;
            o_high   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_lock   <= 1'b0;
            o_lost   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // Ratios 0 and 1 are divider bypass: nothing to check.
                    if (i_div_ratio > RATIO_WD'(1)) begin
                        ratio_q <= i_div_ratio;
                        idle_q  <= '0;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cnt_q  <= CNT_ONE;
                        idle_q <= '0;
                        o_lost <= 1'b0;
                        state  <= TRACK;
                    end else if (timeout_hit) begin
                        o_lost  <= 1'b1;
                        o_lock  <= 1'b0;
                        match_q <= '0;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        o_period <= cnt_q;
                        o_high   <= hi_q;
                        o_valid  <= 1'b1;
                        if (period_good) begin
                            if (match_q != MATCH_MAX) begin
                                match_q <= match_q + 1'b1;
                            end
                            o_lock <= (match_q >= MATCH_PRE);
                        end else begin
                            o_err   <= 1'b1;
                            match_q <= '0;
                            o_lock  <= 1'b0;
                        end
                        cnt_q  <= CNT_ONE;
                        idle_q <= '0;
                        o_lost <= 1'b0;
                    end else begin
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (fall) begin
                            hi_q <= cnt_q;
                        end
                        if (timeout_hit) begin
                            o_lost  <= 1'b1;
                            o_lock  <= 1'b0;
                            match_q <= '0;
                            idle_q  <= '0;
                            state   <= ARM;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_checker.sv
// Randomised self-checking bench for clk_div_checker, compared every reference
// cycle against a rise-to-rise measurement model of the divided clock.
module tb_clk_div_checker;

    localparam int RATIO_WD   = 4;
    localparam int CNT_WD     = 6;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 40;

    logic                i_ref_clk = 1'b0;
    logic                i_rst;
    logic                i_chk_en;
    logic [RATIO_WD-1:0] i_div_ratio;
    logic                i_div_clk;
    logic [CNT_WD-1:0]   o_period;
    logic [CNT_WD-1:0]   o_high;
    logic                o_valid;
    logic                o_err;
    logic                o_lock;
    logic                o_lost;

    int errors = 0;
    int checks = 0;

    // Reference model: measurements taken between consecutive sampled rises.
    bit          m_active;
    bit          m_seen;
    bit          m_prev;
    int          m_ratio;
    int          m_n;
    int          m_last;
    int          m_hcnt;
    int          m_idle;
    int          m_streak;
    logic [5:0]  exp_period;
    logic [5:0]  exp_high;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_lock;
    logic        exp_lost;

    bit wave[$];

    clk_div_checker #(
        .RATIO_WD   (RATIO_WD),
        .CNT_WD     (CNT_WD),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst       (i_rst),
        .i_chk_en    (i_chk_en),
        .i_div_ratio (i_div_ratio),
        .i_div_clk   (i_div_clk),
        .o_period    (o_period),
        .o_high      (o_high),
        .o_valid     (o_valid),
        .o_err       (o_err),
        .o_lock      (o_lock),
        .o_lost      (o_lost)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] obs_vec();
        return {o_period, o_high, o_valid, o_err, o_lock, o_lost};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_period, exp_high, exp_valid, exp_err, exp_lock, exp_lost};
    endfunction

    function automatic string show(input logic [15:0] v);
        return $sformatf("period=%0d high=%0d valid=%0b err=%0b lock=%0b lost=%0b",
                         v[15:10], v[9:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic model_edge(input bit v);
        bit rise;
        bit good;
        int per;
        m_n++;
        rise = v && !m_prev;
        m_prev = v;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        if (i_rst || !i_chk_en) begin
            if (i_rst) m_prev = 1'b0;
            m_active = 1'b0;
            exp_period = '0;
            exp_high = '0;
            exp_lock = 1'b0;
            exp_lost = 1'b0;
        end else if (!m_active) begin
            if (i_div_ratio >= 2) begin
                m_active = 1'b1;
                m_ratio = int'(i_div_ratio);
                m_seen = 1'b0;
                m_idle = 0;
                m_streak = 0;
            end
        end else if (rise) begin
            if (m_seen) begin
                per = m_n - m_last;
                good = (per == m_ratio) &&
                       ((m_hcnt == m_ratio / 2) || (m_hcnt == (m_ratio + 1) / 2));
                exp_valid = 1'b1;
                exp_err = !good;
                exp_period = 6'(per > 63 ? 63 : per);
                exp_high = 6'(m_hcnt > 63 ? 63 : m_hcnt);
                m_streak = good ? ((m_streak < LOCK_COUNT) ? m_streak + 1 : m_streak) : 0;
                exp_lock = (m_streak == LOCK_COUNT);
            end
            m_seen = 1'b1;
            m_last = m_n;
            m_hcnt = 1;
            m_idle = 0;
            exp_lost = 1'b0;
        end else begin
            if (v) m_hcnt++;
            m_idle++;
            if (m_idle == TIMEOUT) begin
                exp_lost = 1'b1;
                exp_lock = 1'b0;
                m_streak = 0;
                m_seen = 1'b0;
                m_idle = 0;
            end
        end
    endtask

    task automatic tick(input bit v);
        i_div_clk = v;
        @(posedge i_ref_clk);
        #1;
        model_edge(v);
    endtask

    task automatic push_wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) wave.push_back(1'b1);
            for (int j = 0; j < lo; j++) wave.push_back(1'b0);
        end
    endtask

    task automatic push_level(input bit v, input int n);
        for (int j = 0; j < n; j++) wave.push_back(v);
    endtask

    task automatic test_reset();
        wave.delete();
        push_level(1'b0, 4);
        foreach (wave[i]) begin
            if (i == 2) i_rst = 1'b0;
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL reset cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            if (obs_vec() !== exp_vec()) errors++;
        end
        checks++;
        if (obs_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_zero: got %s, expected all zero", show(obs_vec()));
        end
    endtask

    task automatic test_ratio4();
        int nval = 0;
        int nerr = 0;
        i_div_ratio = 4'd4;
        i_chk_en = 1'b1;
        wave.delete();
        push_level(1'b0, 3);
        push_wave(2, 2, 6);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio4 cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_err) nerr++;
            if (o_valid) begin
                nval++;
                if (nval <= 3) begin
                    checks++;
                    if (o_lock !== (nval == 3)) begin
                        errors++;
                        $display("FAIL ratio4_lock report %0d: got lock=%0b, expected %0b", nval, o_lock, (nval == 3));
                    end
                end
            end
        end
        checks++;
        if (nval != 5 || nerr != 0) begin
            errors++;
            $display("FAIL ratio4_counts: got reports=%0d errs=%0d, expected reports=5 errs=0", nval, nerr);
        end
    endtask

    task automatic test_ratio5();
        int nval = 0;
        int nerr = 0;
        i_chk_en = 1'b0;
        wave.delete();
        push_level(1'b0, 1);
        foreach (wave[i]) tick(wave[i]);
        i_div_ratio = 4'd5;
        i_chk_en = 1'b1;
        wave.delete();
        push_level(1'b0, 3);
        push_wave(2, 3, 5);
        push_wave(3, 2, 5);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio5 cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_valid) nval++;
            if (o_err) nerr++;
        end
        checks++;
        if (nval != 10 || nerr != 0) begin
            errors++;
            $display("FAIL ratio5_counts: got reports=%0d errs=%0d, expected reports=10 errs=0", nval, nerr);
        end
    endtask

    task automatic test_mismatch();
        int nerr = 0;
        int post = 0;
        i_chk_en = 1'b0;
        tick(1'b0);
        i_div_ratio = 4'd4;
        i_chk_en = 1'b1;
        wave.delete();
        push_level(1'b0, 2);
        push_wave(2, 2, 4);
        push_wave(3, 3, 1);
        push_wave(2, 2, 5);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mismatch cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_err) begin
                nerr++;
                checks++;
                if (o_period !== 6'd6 || o_lock !== 1'b0) begin
                    errors++;
                    $display("FAIL mismatch_pulse: got period=%0d lock=%0b, expected period=6 lock=0", o_period, o_lock);
                end
            end else if (o_valid && nerr == 1) begin
                post++;
                if (post == 3) begin
                    checks++;
                    if (o_lock !== 1'b1) begin
                        errors++;
                        $display("FAIL mismatch_relock: got lock=%0b, expected 1", o_lock);
                    end
                end
            end
        end
        checks++;
        if (nerr != 1) begin
            errors++;
            $display("FAIL mismatch_count: got errs=%0d, expected 1", nerr);
        end
    endtask

    task automatic test_timeout();
        int last_v = 0;
        int gap = -1;
        i_chk_en = 1'b0;
        tick(1'b0);
        i_div_ratio = 4'd4;
        i_chk_en = 1'b1;
        wave.delete();
        push_level(1'b0, 2);
        push_wave(2, 2, 4);
        push_level(1'b1, 2);
        push_level(1'b0, 45);
        push_wave(2, 2, 3);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_valid) last_v = m_n;
            if (o_lost && gap < 0) gap = m_n - last_v;
        end
        checks++;
        if (gap != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_gap: got %0d cycles from last report to lost, expected %0d", gap, TIMEOUT);
        end
    endtask

    task automatic test_reset_midop();
        i_chk_en = 1'b0;
        tick(1'b0);
        i_div_ratio = 4'd4;
        i_chk_en = 1'b1;
        wave.delete();
        push_level(1'b0, 2);
        push_wave(2, 2, 5);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midop_pre cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
        end
        #3;
        i_rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL midop_async: got %s, expected all zero", show(obs_vec()));
        end
        tick(1'b1);
        tick(1'b0);
        i_rst = 1'b0;
        wave.delete();
        push_level(1'b0, 1);
        push_wave(2, 2, 5);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midop_post cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
        end
    endtask

    task automatic test_bypass();
        int nerr = 0;
        i_chk_en = 1'b0;
        tick(1'b0);
        i_div_ratio = 4'd1;
        i_chk_en = 1'b1;
        wave.delete();
        push_wave(1, 1, 25);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== 16'h0000 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bypass cycle %0d: got %s, expected all zero", m_n, show(obs_vec()));
            end
        end
        i_div_ratio = 4'd4;
        wave.delete();
        push_level(1'b0, 2);
        push_wave(2, 2, 5);
        foreach (wave[i]) tick(wave[i]);
        i_div_ratio = 4'd7;
        wave.delete();
        push_wave(2, 2, 4);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio_ignored cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_err) nerr++;
        end
        checks++;
        if (nerr != 0 || o_lock !== 1'b1) begin
            errors++;
            $display("FAIL ratio_ignored_sum: got errs=%0d lock=%0b, expected errs=0 lock=1", nerr, o_lock);
        end
        i_chk_en = 1'b0;
        tick(1'b0);
        i_chk_en = 1'b1;
        nerr = 0;
        wave.delete();
        push_level(1'b0, 2);
        push_wave(2, 2, 4);
        push_level(1'b1, 1);
        foreach (wave[i]) begin
            tick(wave[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ratio_relatch cycle %0d: got %s, expected %s", m_n, show(obs_vec()), show(exp_vec()));
            end
            if (o_err) nerr++;
        end
        checks++;
        if (nerr != 4) begin
            errors++;
            $display("FAIL ratio_relatch_errs: got %0d, expected 4", nerr);
        end
    endtask

    task automatic test_random();
        int r;
        int n;
        int sel;
        int hi;
        int lo;
        int tot;
        for (int seg = 0; seg < 25; seg++) begin
            r = $urandom_range(9, 2);
            i_chk_en = 1'b0;
            tick(1'b0);
            i_div_ratio = 4'(r);
            i_chk_en = 1'b1;
            wave.delete();
            push_level(1'b0, 2);
            n = $urandom_range(16, 6);
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(7, 0);
                if (sel < 5) begin
                    hi = (sel % 2 == 1) ? r / 2 : (r + 1) / 2;
                    lo = r - hi;
                end else if (sel == 5) begin
                    tot = $urandom_range(12, 2);
                    hi = $urandom_range(tot - 1, 1);
                    lo = tot - hi;
                end else begin
                    hi = $urandom_range(3, 1);
                    lo = $urandom_range(41, 37) - hi;
                end
                push_wave(hi, lo, 1);
            end
            push_level(1'b1, 1);
            foreach (wave[i]) begin
                if (i == 4) i_div_ratio = 4'($urandom);
                tick(wave[i]);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random seg %0d cycle %0d: got %s, expected %s", seg, m_n, show(obs_vec()), show(exp_vec()));
                end
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_chk_en = 1'b0;
        i_div_ratio = '0;
        i_div_clk = 1'b0;
        m_active = 1'b0;
        m_seen = 1'b0;
        m_prev = 1'b0;
        m_ratio = 0;
        m_n = 0;
        m_last = 0;
        m_hcnt = 0;
        m_idle = 0;
        m_streak = 0;
        exp_period = '0;
        exp_high = '0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        exp_lock = 1'b0;
        exp_lost = 1'b0;

        test_reset();
        test_ratio4();
        test_ratio5();
        test_mismatch();
        test_timeout();
        test_reset_midop();
        test_bypass();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
